hwacc_icm_lookup_arbiter: RTL and testbench



---
 rtl/hwacc_icm_lookup_arbiter_pkg.sv | 25 ++
 rtl/hwacc_icm_lookup_arbiter_if.sv | 31 +++
 rtl/hwacc_rr_picker.sv | 42 ++++
 rtl/hwacc_icm_lookup_arbiter.sv | 130 +++++++++++++
 tb/tb_hwacc_icm_lookup_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwacc_icm_lookup_arbiter_pkg.sv
// Shared definitions for the ICM lookup arbiter and its round-robin picker.
//   - arb_state_e     : FSM state encoding (3-bit, one value per phase)
//   - DEFAULT_*       : default sizing for requester count and bus widths
//   - rr_wrap()       : single-subtract modulo used by the round-robin scan
package hwacc_icm_lookup_arbiter_pkg;

  localparam int DEFAULT_REQ_NUM             = 4;
  localparam int DEFAULT_ICM_ENTRY_NUM_LOG   = 16;
  localparam int DEFAULT_ICM_ADDR_WIDTH      = 64;
  localparam int DEFAULT_PHYSICAL_ADDR_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_DELIVER  = 3'd4
  } arb_state_e;

  // idx is at most 2n-1 in every caller, so one conditional subtract is a
  // full modulo and avoids a divider for non-power-of-two n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/hwacc_icm_lookup_arbiter_if.sv
// ICM mapping table channel: one lookup request (entry index) and one
// mapping response (ICM address + physical address), each valid/ready.
//   master : the side issuing lookups and consuming responses (arbiter)
//   slave  : the mapping table
interface hwacc_icm_lookup_arbiter_if
  import hwacc_icm_lookup_arbiter_pkg::*;
#(
  parameter int ICM_ENTRY_NUM_LOG   = DEFAULT_ICM_ENTRY_NUM_LOG,
  parameter int ICM_ADDR_WIDTH      = DEFAULT_ICM_ADDR_WIDTH,
  parameter int PHYSICAL_ADDR_WIDTH = DEFAULT_PHYSICAL_ADDR_WIDTH
);

  logic                           lookup_valid;
  logic [ICM_ENTRY_NUM_LOG-1:0]   lookup_head;
  logic                           lookup_ready;
  logic                           rsp_valid;
  logic [ICM_ADDR_WIDTH-1:0]      rsp_icm_addr;
  logic [PHYSICAL_ADDR_WIDTH-1:0] rsp_phy_addr;
  logic                           rsp_ready;

  modport master (
    output lookup_valid, lookup_head, rsp_ready,
    input  lookup_ready, rsp_valid, rsp_icm_addr, rsp_phy_addr
  );

  modport slave (
    input  lookup_valid, lookup_head, rsp_ready,
    output lookup_ready, rsp_valid, rsp_icm_addr, rsp_phy_addr
  );

endinterface

// File: rtl/hwacc_rr_picker.sv
// Combinational round-robin picker.
//   req        in  N   request vector
//   last_grant in  IW  index granted last time; the scan starts one past it
//   gnt        out N   one-hot winner (all zero when nothing requests)
//   gnt_idx    out IW  binary index of the winner
//   any_gnt    out 1   at least one request present
module hwacc_rr_picker
  import hwacc_icm_lookup_arbiter_pkg::*;
#(
  parameter  int N  = DEFAULT_REQ_NUM,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  int            idx;
  logic [IW-1:0] sel;

  // Scan last_grant+1 .. last_grant+N (wrapped); the first hit wins, so the
  // previous winner is checked last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = rr_wrap(int'(last_grant) + k, N);
      sel = IW'(idx);
      if (!any_gnt && req[sel]) begin
        any_gnt  = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/hwacc_icm_lookup_arbiter.sv
// Shares the single ICM mapping lookup channel among REQ_NUM context-
// management threads. One lookup is outstanding at a time; the winner is
// chosen round-robin and the mapping response is returned only to it.
//   clk, rst          clock; asynchronous active-high reset
//   req_lookup_*      per-thread lookup request (valid, packed head, ready)
//   req_rsp_*         one-hot response valid, shared address buses,
//                     per-thread response ready
//   icm_mapping       master side of the mapping table channel
// Sequence: IDLE (accept) -> ISSUE (lookup) -> WAIT_RSP -> DELIVER -> IDLE.
module hwacc_icm_lookup_arbiter
  import hwacc_icm_lookup_arbiter_pkg::*;
#(
  parameter int REQ_NUM             = DEFAULT_REQ_NUM,
  parameter int ICM_ENTRY_NUM_LOG   = DEFAULT_ICM_ENTRY_NUM_LOG,
  parameter int ICM_ADDR_WIDTH      = DEFAULT_ICM_ADDR_WIDTH,
  parameter int PHYSICAL_ADDR_WIDTH = DEFAULT_PHYSICAL_ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REQ_NUM-1:0]                   req_lookup_valid,
  input  logic [REQ_NUM*ICM_ENTRY_NUM_LOG-1:0] req_lookup_head,
  output logic [REQ_NUM-1:0]                   req_lookup_ready,
  output logic [REQ_NUM-1:0]                   req_rsp_valid,
  output logic [ICM_ADDR_WIDTH-1:0]            req_rsp_icm_addr,
  output logic [PHYSICAL_ADDR_WIDTH-1:0]       req_rsp_phy_addr,
  input  logic [REQ_NUM-1:0]                   req_rsp_ready,
  hwacc_icm_lookup_arbiter_if.master           icm_mapping
);

  localparam int IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  arb_state_e                     state_q, state_d;
  logic [IW-1:0]                  last_grant_q, last_grant_d;
  logic [IW-1:0]                  grant_q, grant_d;
  logic [ICM_ENTRY_NUM_LOG-1:0]   head_q, head_d;
  logic [ICM_ADDR_WIDTH-1:0]      icm_addr_q, icm_addr_d;
  logic [PHYSICAL_ADDR_WIDTH-1:0] phy_addr_q, phy_addr_d;

  logic [REQ_NUM-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [REQ_NUM-1:0] grant_sel;

  hwacc_rr_picker #(.N(REQ_NUM)) u_picker (
    .req        (req_lookup_valid),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .gnt_idx    (pick_idx),
    .any_gnt    (pick_any)
  );

  // One-hot decode of the latched grant; routes the response and masks
  // response-ready from threads that do not own the current lookup.
  for (genvar g = 0; g < REQ_NUM; g++) begin : g_sel
    assign grant_sel[g] = (grant_q == IW'(g));
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    head_d       = head_q;
    icm_addr_d   = icm_addr_q;
    phy_addr_d   = phy_addr_q;

    req_lookup_ready         = '0;
    req_rsp_valid            = '0;
    req_rsp_icm_addr         = '0;
    req_rsp_phy_addr         = '0;
    icm_mapping.lookup_valid = 1'b0;
    icm_mapping.lookup_head  = '0;
    icm_mapping.rsp_ready    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Accept is combinational on the requester's valid; it is held off
        // while rst is high so no thread sees a handshake the flops drop.
        if (pick_any && !rst) begin
          req_lookup_ready = pick_gnt;
          grant_d          = pick_idx;
          head_d           = req_lookup_head[int'(pick_idx)*ICM_ENTRY_NUM_LOG +: ICM_ENTRY_NUM_LOG];
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        icm_mapping.lookup_valid = 1'b1;
        icm_mapping.lookup_head  = head_q;
        if (icm_mapping.lookup_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        icm_mapping.rsp_ready = 1'b1;
        if (icm_mapping.rsp_valid) begin
          icm_addr_d = icm_mapping.rsp_icm_addr;
          phy_addr_d = icm_mapping.rsp_phy_addr;
          state_d    = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        req_rsp_valid    = grant_sel;
        req_rsp_icm_addr = icm_addr_q;
        req_rsp_phy_addr = phy_addr_q;
        // Priority pointer moves only once the owner has taken its answer.
        if (|(grant_sel & req_rsp_ready)) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(REQ_NUM - 1);
      grant_q      <= '0;
      head_q       <= '0;
      icm_addr_q   <= '0;
      phy_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      head_q       <= head_d;
      icm_addr_q   <= icm_addr_d;
      phy_addr_q   <= phy_addr_d;
    end
  end

endmodule

// File: tb/tb_hwacc_icm_lookup_arbiter.sv
// Bench for hwacc_icm_lookup_arbiter (REQ_NUM=4, 16-bit heads, 64-bit addrs).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_hwacc_icm_lookup_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_lookup_valid;
  logic [N*W-1:0]  req_lookup_head;
  logic [N-1:0]    req_lookup_ready;
  logic [N-1:0]    req_rsp_valid;
  logic [63:0]     req_rsp_icm_addr;
  logic [63:0]     req_rsp_phy_addr;
  logic [N-1:0]    req_rsp_ready;

  int checks = 0;
  int errors = 0;

  hwacc_icm_lookup_arbiter_if #(.ICM_ENTRY_NUM_LOG(W), .ICM_ADDR_WIDTH(64),
                                .PHYSICAL_ADDR_WIDTH(64)) map_if ();

  hwacc_icm_lookup_arbiter #(.REQ_NUM(N), .ICM_ENTRY_NUM_LOG(W),
                             .ICM_ADDR_WIDTH(64), .PHYSICAL_ADDR_WIDTH(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_lookup_valid (req_lookup_valid),
    .req_lookup_head  (req_lookup_head),
    .req_lookup_ready (req_lookup_ready),
    .req_rsp_valid    (req_rsp_valid),
    .req_rsp_icm_addr (req_rsp_icm_addr),
    .req_rsp_phy_addr (req_rsp_phy_addr),
    .req_rsp_ready    (req_rsp_ready),
    .icm_mapping      (map_if)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic quiet(input string nm);
    chk(nm, {req_lookup_ready, req_rsp_valid, req_rsp_icm_addr, req_rsp_phy_addr,
             map_if.lookup_valid, map_if.lookup_head, map_if.rsp_ready}, '0);
  endtask

  task automatic clear_inputs();
    req_lookup_valid    = '0;
    req_lookup_head     = '0;
    req_rsp_ready       = '0;
    map_if.lookup_ready = 1'b0;
    map_if.rsp_valid    = 1'b0;
    map_if.rsp_icm_addr = '0;
    map_if.rsp_phy_addr = '0;
  endtask

  // Leaves the bench at a falling edge with inputs cleared, arbiter idle.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction for thread g, entered right after a falling edge
  // with requests already driven and the arbiter idle. The mapping table
  // stalls lookup_ready for lk_stall cycles and answers the cycle after the
  // lookup; thread g holds off response-ready for dl_stall cycles while the
  // other threads assert theirs.
  task automatic serve(input int g, input logic [N-1:0] sel, input bit drop,
                       input int lk_stall, input int dl_stall,
                       input logic [63:0] icm, input logic [63:0] phy);
    logic [W-1:0] eh;
    int t;
    eh = req_lookup_head[g*W +: W];
    #1;
    t = 0;
    while (req_lookup_ready == '0 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("accept", req_lookup_ready, sel);
    chk("accept_lat", t, 0);
    if (req_lookup_ready == '0) return;
    @(negedge clk);
    if (drop) req_lookup_valid[g] = 1'b0;
    for (int s = 0; s <= lk_stall; s++) begin
      map_if.lookup_ready = (s == lk_stall);
      #1;
      chk("lk_valid", map_if.lookup_valid, 1'b1);
      chk("lk_head", map_if.lookup_head, eh);
      chk("no_regrant_lk", req_lookup_ready, '0);
      @(negedge clk);
    end
    map_if.lookup_ready = 1'b0;
    map_if.rsp_valid    = 1'b1;
    map_if.rsp_icm_addr = icm;
    map_if.rsp_phy_addr = phy;
    #1;
    chk("map_rsp_ready", map_if.rsp_ready, 1'b1);
    chk("lk_dropped", map_if.lookup_valid, 1'b0);
    @(negedge clk);
    map_if.rsp_valid    = 1'b0;
    map_if.rsp_icm_addr = ~icm;
    map_if.rsp_phy_addr = ~phy;
    for (int s = 0; s <= dl_stall; s++) begin
      req_rsp_ready = (s == dl_stall) ? sel : ~sel;
      #1;
      chk("rsp_valid", req_rsp_valid, sel);
      chk("rsp_icm", req_rsp_icm_addr, icm);
      chk("rsp_phy", req_rsp_phy_addr, phy);
      chk("no_regrant_dl", req_lookup_ready, '0);
      @(negedge clk);
    end
    req_rsp_ready = '0;
  endtask

  typedef struct {
    int          thr;
    logic [15:0] head;
    logic [63:0] icm;
    logic [63:0] phy;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t vt[4];
  int   order[4];

  // random-phase reference state
  int          thr_st[N];     // 0 idle, 1 requesting, 2 awaiting answer
  int          waitc[N];      // grants given to others while requesting
  bit          busy, lk_done, rsp_given, inwin, dl;
  int          tg, rsp_wait, m_last, w, ii;
  logic [15:0] th;
  logic [63:0] e_icm, e_phy;

  initial begin
    vt[0] = '{thr: 2, head: 16'h0123, icm: 64'hA000,            phy: 64'hB000,            exp_ready: 4'b0100};
    vt[1] = '{thr: 0, head: 16'h0000, icm: 64'h1,               phy: 64'h2,               exp_ready: 4'b0001};
    vt[2] = '{thr: 3, head: 16'hFFFF, icm: 64'hFFFF_FFFF_FFFF_FFFF, phy: 64'h0,           exp_ready: 4'b1000};
    vt[3] = '{thr: 1, head: 16'h5A5A, icm: 64'h8000_0000_0000_0001, phy: 64'h1234_5678_9ABC_DEF0, exp_ready: 4'b0010};

    // reset: every output stays 0 even with all threads requesting
    rst = 1'b1;
    clear_inputs();
    req_lookup_valid = '1;
    map_if.rsp_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1 quiet("reset_quiet");
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1 quiet("post_reset");
    @(negedge clk);

    // single-requester vectors
    foreach (vt[v]) begin
      req_lookup_valid[vt[v].thr] = 1'b1;
      req_lookup_head[vt[v].thr*W +: W] = vt[v].head;
      serve(vt[v].thr, vt[v].exp_ready, 1'b1, 0, 0, vt[v].icm, vt[v].phy);
    end
    #1 quiet("idle_after_table");

    // unsolicited mapping response while idle
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      map_if.rsp_valid    = 1'b1;
      map_if.rsp_icm_addr = 64'hDEAD;
      map_if.rsp_phy_addr = 64'hBEEF;
      #1 quiet("unsolicited");
      @(negedge clk);
    end
    map_if.rsp_valid = 1'b0;

    // reset while waiting for the mapping response
    req_lookup_valid[3] = 1'b1;
    req_lookup_head[3*W +: W] = 16'h0BEE;
    #1 chk("rst_mid_accept", req_lookup_ready, 4'b1000);
    @(negedge clk);
    req_lookup_valid[3] = 1'b0;
    map_if.lookup_ready = 1'b1;
    #1 chk("rst_mid_lk", {map_if.lookup_valid, map_if.lookup_head}, {1'b1, 16'h0BEE});
    @(negedge clk);
    map_if.lookup_ready = 1'b0;
    #1 chk("rst_mid_wait", map_if.rsp_ready, 1'b1);
    #1 rst = 1'b1;
    #1 quiet("rst_mid_asserted");
    map_if.rsp_valid    = 1'b1;
    map_if.rsp_icm_addr = 64'h7777;
    #1 quiet("rst_mid_late_rsp");
    @(negedge clk);
    rst = 1'b0;
    #1 quiet("rst_mid_released");
    @(negedge clk);
    map_if.rsp_valid = 1'b0;
    #1 quiet("rst_mid_idle");
    @(negedge clk);

    // all four requesting continuously: strict rotation, backpressure on 2nd
    for (int i = 0; i < N; i++) req_lookup_head[i*W +: W] = 16'(16'h1000 + i);
    req_lookup_valid = '1;
    order = '{0, 1, 2, 3};
    for (int k = 0; k < 5; k++) begin
      serve(order[k % 4], 4'b0001 << order[k % 4], 1'b0,
            (k == 1) ? 5 : 0, (k == 1) ? 3 : 0,
            64'hC000 + 64'(k), 64'hD000 + 64'(k));
    end

    // thread 1 silent: rotation skips it
    pulse_reset();
    for (int i = 0; i < N; i++) req_lookup_head[i*W +: W] = 16'(16'h2000 + i);
    req_lookup_valid = 4'b1101;
    order = '{0, 2, 3, 0};
    for (int k = 0; k < 4; k++)
      serve(order[k], 4'b0001 << order[k], 1'b0, 0, 0, 64'hE000 + 64'(k), 64'hF000 + 64'(k));

    // randomized traffic against a transaction-level reference
    pulse_reset();
    m_last = N - 1;
    busy = 0; lk_done = 0; rsp_given = 0; tg = 0; rsp_wait = 0; th = '0;
    e_icm = '0; e_phy = '0;
    for (int i = 0; i < N; i++) begin thr_st[i] = 0; waitc[i] = 0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc != 0) @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (thr_st[i] == 0 && $urandom_range(0, 3) == 0) begin
          thr_st[i] = 1;
          req_lookup_head[i*W +: W] = 16'($urandom);
        end
        req_lookup_valid[i] = (thr_st[i] == 1);
      end
      req_rsp_ready       = 4'($urandom);
      map_if.lookup_ready = ($urandom_range(0, 2) != 0);
      inwin = busy && lk_done && !rsp_given;
      if (inwin && rsp_wait == 0) begin
        map_if.rsp_valid    = 1'b1;
        map_if.rsp_icm_addr = e_icm;
        map_if.rsp_phy_addr = e_phy;
      end else begin
        if (inwin) rsp_wait--;
        map_if.rsp_valid    = !inwin && ($urandom_range(0, 4) == 0);
        map_if.rsp_icm_addr = {$urandom, $urandom};
        map_if.rsp_phy_addr = {$urandom, $urandom};
      end
      #1;
      w = -1;
      if (!busy) begin
        for (int k = 1; k <= N; k++) begin
          ii = (m_last + k) % N;
          if (w < 0 && req_lookup_valid[ii]) w = ii;
        end
      end
      dl = busy && rsp_given;
      chk("rnd_accept", req_lookup_ready, (w >= 0) ? (4'b0001 << w) : 4'b0000);
      chk("rnd_lk_valid", map_if.lookup_valid, busy && !lk_done);
      chk("rnd_lk_head", map_if.lookup_head, (busy && !lk_done) ? th : 16'h0);
      chk("rnd_map_rsp_ready", map_if.rsp_ready, inwin);
      chk("rnd_rsp_valid", req_rsp_valid, dl ? (4'b0001 << tg) : 4'b0000);
      chk("rnd_rsp_icm", req_rsp_icm_addr, dl ? e_icm : 64'h0);
      chk("rnd_rsp_phy", req_rsp_phy_addr, dl ? e_phy : 64'h0);
      if (w >= 0) begin
        chk("rnd_fair", waitc[w] <= N - 1, 1'b1);
        for (int i = 0; i < N; i++) if (i != w && thr_st[i] == 1) waitc[i]++;
        waitc[w]  = 0;
        busy      = 1;
        tg        = w;
        th        = req_lookup_head[w*W +: W];
        lk_done   = 0;
        rsp_given = 0;
        thr_st[w] = 2;
      end else if (busy && !lk_done) begin
        if (map_if.lookup_ready) begin
          lk_done  = 1;
          rsp_wait = $urandom_range(0, 3);
          e_icm    = {$urandom, $urandom};
          e_phy    = {$urandom, $urandom};
        end
      end else if (inwin) begin
        if (map_if.rsp_valid) rsp_given = 1;
      end else if (dl && req_rsp_ready[tg]) begin
        busy       = 0;
        m_last     = tg;
        thr_st[tg] = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
